// File: rtl/logic_gate_pkg.sv
// Shared types and sizing constants for the logic_gate_pipe datapath.
package logic_gate_pkg;

  typedef enum logic [1:0] {
    GATE_AND  = 2'b00,
    GATE_OR   = 2'b01,
    GATE_XOR  = 2'b10,
    GATE_NAND = 2'b11
  } gate_op_e;

  localparam int unsigned GATE_FIFO_DEPTH = 2;
  localparam int unsigned GATE_CNT_W      = 16;

endpackage : logic_gate_pkg

// File: rtl/logic_gate_pipe_fifo2.sv
// gate_fifo2: two-entry synchronous FIFO with registered valid/ready flags.
// ready only depends on registered occupancy, so there is no path from pop.
module gate_fifo2
  import logic_gate_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         ready
);

  localparam int unsigned PTR_W = (GATE_FIFO_DEPTH > 1) ? $clog2(GATE_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(GATE_FIFO_DEPTH + 1);

  logic [W-1:0]     mem [GATE_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the registered flags and compute next occupancy.
  always_comb begin
    do_push   = push & ready;
    do_pop    = pop & valid;
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage, pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(GATE_FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      ready  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      valid <= (count_nxt != '0);
      ready <= (count_nxt != CNT_W'(GATE_FIFO_DEPTH));
    end
  end

  // Head entry is always presented; consumers qualify it with valid.
  assign rdata = mem[rd_ptr];

endmodule : gate_fifo2

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: NUM_IN-operand bitwise AND/OR/XOR/NAND with a 2-entry
// valid/ready output FIFO. Optional accept counter under GATE_PIPE_STATS_EN.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero
`ifdef GATE_PIPE_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [GATE_CNT_W-1:0]   acc_count
`endif
);

  logic [WIDTH-1:0] all_and;
  logic [WIDTH-1:0] any_or;
  logic [WIDTH-1:0] par_xor;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   head;

  // Per-bit reduction across all operands, then select by op.
  always_comb begin
    all_and = '1;
    any_or  = '0;
    par_xor = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      all_and = all_and & in_data[k*WIDTH +: WIDTH];
      any_or  = any_or  | in_data[k*WIDTH +: WIDTH];
      par_xor = par_xor ^ in_data[k*WIDTH +: WIDTH];
    end
    case (gate_op_e'(in_op))
      GATE_AND:  result = all_and;
      GATE_OR:   result = any_or;
      GATE_XOR:  result = par_xor;
      GATE_NAND: result = ~all_and;
      default:   result = all_and;
    endcase
  end

  // Result and its zero flag travel together through the FIFO.
  gate_fifo2 #(
    .W (WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata ({(result == '0), result}),
    .pop   (out_ready),
    .rdata (head),
    .valid (out_valid),
    .ready (in_ready)
  );

  assign out_data = head[WIDTH-1:0];
  assign out_zero = head[WIDTH];

`ifdef GATE_PIPE_STATS_EN
  // Saturating accept counter; clear has priority over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_count <= '0;
    end else if (stats_clr) begin
      acc_count <= '0;
    end else if (in_valid && in_ready && (acc_count != {GATE_CNT_W{1'b1}})) begin
      acc_count <= acc_count + GATE_CNT_W'(1);
    end
  end
`endif

endmodule : logic_gate_pipe

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: a 2-operand and a 4-operand instance.
// Expected results come from a per-bit population-count model of each op.
module tb_logic_gate_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_zero;
  logic [15:0] a_in_data = '0;
  logic [1:0]  a_in_op = '0;
  logic [7:0]  a_out_data;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_zero;
  logic [31:0] b_in_data = '0;
  logic [1:0]  b_in_op = '0;
  logic [7:0]  b_out_data;

`ifdef GATE_PIPE_STATS_EN
  logic        a_stats_clr = 1'b0, b_stats_clr = 1'b0;
  logic [15:0] a_acc_count, b_acc_count;
  int          a_acc_exp = 0, b_acc_exp = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_op     (a_in_op),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_zero  (a_out_zero)
`ifdef GATE_PIPE_STATS_EN
    ,
    .stats_clr (a_stats_clr),
    .acc_count (a_acc_count)
`endif
  );

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_op     (b_in_op),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_zero  (b_out_zero)
`ifdef GATE_PIPE_STATS_EN
    ,
    .stats_clr (b_stats_clr),
    .acc_count (b_acc_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per bit: count operands with a 1, then apply the op's rule to that count.
  function automatic logic [8:0] model(input logic [1:0] op, input logic [31:0] data, input int n);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      int ones = 0;
      for (int k = 0; k < n; k++) ones += int'(data[k*8 + b]);
      case (op)
        2'd0:    r[b] = (ones == n);
        2'd1:    r[b] = (ones > 0);
        2'd2:    r[b] = (ones % 2 == 1);
        default: r[b] = (ones != n);
      endcase
    end
    return {(r == 8'h00), r};
  endfunction

  // Monitor + scoreboard: inputs change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (a_out_valid) begin
        if (qa.size() == 0) chk("a_spurious_valid", 32'(a_out_valid), 32'd0);
        else begin
          e = qa[0];
          chk("a_data", 32'(a_out_data), 32'(e[7:0]));
          chk("a_zero", 32'(a_out_zero), 32'(e[8]));
          if (a_out_ready) void'(qa.pop_front());
        end
      end
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b_spurious_valid", 32'(b_out_valid), 32'd0);
        else begin
          e = qb[0];
          chk("b_data", 32'(b_out_data), 32'(e[7:0]));
          chk("b_zero", 32'(b_out_zero), 32'(e[8]));
          if (b_out_ready) void'(qb.pop_front());
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(model(a_in_op, {16'h0, a_in_data}, 2));
      if (b_in_valid && b_in_ready) qb.push_back(model(b_in_op, b_in_data, 4));
`ifdef GATE_PIPE_STATS_EN
      chk("a_acc_count", 32'(a_acc_count), 32'(a_acc_exp));
      chk("b_acc_count", 32'(b_acc_count), 32'(b_acc_exp));
      if (a_stats_clr) a_acc_exp = 0;
      else if (a_in_valid && a_in_ready && a_acc_exp < 65535) a_acc_exp++;
      if (b_stats_clr) b_acc_exp = 0;
      else if (b_in_valid && b_in_ready && b_acc_exp < 65535) b_acc_exp++;
`endif
    end else begin
`ifdef GATE_PIPE_STATS_EN
      a_acc_exp = 0;
      b_acc_exp = 0;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the current B bundle until it is accepted, bounded.
  task automatic wait_b_accept();
    logic acc;
    int   n = 0;
    do begin
      @(negedge clk);
      acc = b_in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("b_accept_timeout", 32'(acc), 32'd1);
    b_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] op, input logic [31:0] d);
    b_in_valid = 1'b1;
    b_in_op    = op;
    b_in_data  = d;
    wait_b_accept();
  endtask

  localparam logic [7:0] T1_EXP [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};

  initial begin
    // Reset values
    #12;
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data", 32'(a_out_data), 32'd0);
    chk("rst_a_out_zero", 32'(a_out_zero), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("post_rst_b_in_ready", 32'(b_in_ready), 32'd1);
    step();

    // AND/OR/XOR/NAND of F0,3C back-to-back, each visible one edge after accept
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        a_in_valid = 1'b1;
        a_in_op    = 2'(i);
        a_in_data  = {8'h3C, 8'hF0};
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 4) chk("t1_in_ready", 32'(a_in_ready), 32'd1);
      if (i > 0) begin
        chk("t1_out_valid", 32'(a_out_valid), 32'd1);
        chk("t1_out_data", 32'(a_out_data), 32'(T1_EXP[i-1]));
      end
      step();
    end

    // 4-operand XOR then AND of 01,02,04,08
    b_out_ready = 1'b1;
    send_b(2'd2, 32'h08040201);
    @(negedge clk);
    chk("t2_xor_data", 32'(b_out_data), 32'h0F);
    chk("t2_xor_zero", 32'(b_out_zero), 32'd0);
    step();
    send_b(2'd0, 32'h08040201);
    @(negedge clk);
    chk("t2_and_data", 32'(b_out_data), 32'h00);
    chk("t2_and_zero", 32'(b_out_zero), 32'd1);
    chk("t2_and_valid", 32'(b_out_valid), 32'd1);
    step();

    // Backpressure: two fill the FIFO, third is held until drain starts
    b_out_ready = 1'b0;
    repeat (2) step();
    send_b(2'd1, $urandom);
    send_b(2'd2, $urandom);
    b_in_valid = 1'b1;
    b_in_op    = 2'd3;
    b_in_data  = $urandom;
    repeat (3) begin
      @(negedge clk);
      chk("t3_full_in_ready", 32'(b_in_ready), 32'd0);
      step();
    end
    b_out_ready = 1'b1;
    wait_b_accept();
    repeat (4) step();
    @(negedge clk);
    chk("t3_drained_valid", 32'(b_out_valid), 32'd0);
    chk("t3_drained_queue", 32'(qb.size()), 32'd0);
    step();

    // Streaming: one result per cycle, occupancy held at 1
    for (int i = 0; i < 20; i++) begin
      b_in_valid = 1'b1;
      b_in_op    = 2'($urandom_range(0, 3));
      b_in_data  = $urandom;
      @(negedge clk);
      chk("t4_in_ready", 32'(b_in_ready), 32'd1);
      if (i > 0) chk("t4_out_valid", 32'(b_out_valid), 32'd1);
      step();
    end
    b_in_valid = 1'b0;

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = 1'($urandom);
      a_in_op     = 2'($urandom);
      a_in_data   = 16'($urandom);
      a_out_ready = 1'($urandom);
      b_in_valid  = 1'($urandom);
      b_in_op     = 2'($urandom);
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("rand_a_drain", 32'(qa.size()), 32'd0);
    chk("rand_b_drain", 32'(qb.size()), 32'd0);
    step();

    // Asynchronous reset with FIFO full and a bundle pending
    b_out_ready = 1'b0;
    send_b(2'd1, 32'h11223344);
    send_b(2'd2, 32'h55667788);
    b_in_valid = 1'b1;
    b_in_data  = 32'hA5A5A5A5;
    @(negedge clk);
    chk("t5_pre_full", 32'(b_in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(b_out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(b_in_ready), 32'd0);
    chk("t5_rst_out_data", 32'(b_out_data), 32'd0);
    chk("t5_rst_out_zero", 32'(b_out_zero), 32'd0);
    qa.delete();
    qb.delete();
    b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_edge_in_ready", 32'(b_in_ready), 32'd0);
    @(negedge clk);
    chk("t5_rel_in_ready", 32'(b_in_ready), 32'd1);
    chk("t5_rel_out_valid", 32'(b_out_valid), 32'd0);
    step();

`ifdef GATE_PIPE_STATS_EN
    // Accept counting, clear priority, saturation
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_b(2'($urandom), $urandom);
    @(negedge clk);
    chk("t6_count5", 32'(b_acc_count), 32'd5);
    step();
    b_stats_clr = 1'b1;
    b_in_valid  = 1'b1;
    step();
    b_stats_clr = 1'b0;
    b_in_valid  = 1'b0;
    @(negedge clk);
    chk("t6_clear_wins", 32'(b_acc_count), 32'd0);
    step();
    b_in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_saturate", 32'(b_acc_count), 32'hFFFF);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_logic_gate_pipe
